regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Sequences all writes into the 32 x 32-bit register file (x0 hardwired zero, asynchronous read, single synchronous write port).
- Arbitrates the single write port between two writeback sources: ALU (source 0) and load/store unit (source 1), using valid/ready handshakes and round-robin priority.
- Maintains a per-register busy scoreboard, set at issue and cleared at writeback, and flags RAW/WAW hazards to the issue stage.

Parameters:
- XLEN, 32, data width of write data and register contents.
- AW, 5, register index width (2**AW registers, index 0 = x0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU has a result to write back
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- alu_ready  output  1  ALU result accepted this cycle
- lsu_valid  input  1  LSU has load data to write back
- lsu_rd  input  AW  LSU destination register
- lsu_data  input  XLEN  load data
- lsu_ready  output  1  LSU result accepted this cycle
- issue_valid  input  1  instruction issuing this cycle; reserves issue_rd
- issue_rd  input  AW  destination register of the issuing instruction
- chk_rs1  input  AW  source register 1 of the candidate instruction
- chk_rs2  input  AW  source register 2 of the candidate instruction
- chk_rd  input  AW  destination register of the candidate instruction
- hazard  output  1  candidate must stall (RAW on rs1/rs2, or WAW on rd)
- reg_write  output  1  register-file write enable
- write_reg  output  AW  register-file write index
- write_data  output  XLEN  register-file write data

Behaviour:
- Reset is synchronous on the clk edge where reset=1. It clears busy[all], reg_write=0, write_reg=0, write_data=0, and rr_ptr=0 (ALU favoured). Reset overrides every other input that cycle.
- Grant logic is combinational from the current inputs and rr_ptr.
  - Exactly one source valid: that source is granted.
  - Both valid: the source selected by rr_ptr is granted; the other source's ready=0 and it holds valid/rd/data stable.
  - Neither valid: no grant.
- ready is asserted only for the granted source; at most one ready is high per cycle.
- rr_ptr updates only on a contested cycle (both valid); it then points to the loser. An uncontested grant leaves rr_ptr unchanged.
- Output stage is registered with 1-cycle latency. On the edge after a grant: write_reg=granted rd, write_data=granted data, reg_write=(granted rd != 0).
  - No grant: reg_write=0; write_reg and write_data hold their previous values.
  - A grant to rd=0 is accepted (ready=1) and dropped (reg_write=0).
- Scoreboard: busy[1..2**AW-1] registers; busy[0] reads as constant 0.
  - Set: issue_valid && issue_rd != 0 sets busy[issue_rd] at the edge.
  - Clear: a granted writeback to rd != 0 clears busy[rd] at the same edge.
  - Set and clear of the same register at the same edge: set wins, because a new producer exists.
  - Issue to a register that is already busy: busy stays 1. The issuer must have honoured hazard (WAW) beforehand; no counting is performed.
- hazard is combinational. For each r in {chk_rs1, chk_rs2, chk_rd} with r != 0, hazard=1 if either:
  - busy[r]=1, or
  - reg_write=1 && write_reg==r (write sitting in the output stage, not yet visible through the asynchronous register-file read).
- hazard does not consider same-cycle issue_rd or same-cycle grants; it reflects registered state only.

Test Plan:
- Reset held 2 cycles with alu_valid=1, alu_rd=5 -> during reset: reg_write=0, write_reg=0, write_data=0, busy all 0, no scoreboard change. First cycle after release: alu_ready=1.
- ALU alone: alu_rd=3, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle reg_write=1, write_reg=3, write_data=0xDEADBEEF; the following cycle reg_write=0.
- Both valid for 4 cycles with rr_ptr=0 (ALU rd=1/2, LSU rd=7, same data held on loss) -> grant order ALU, LSU, ALU, LSU; one ready per cycle; losing source's values unchanged until granted.
- LSU writeback with lsu_rd=0, lsu_data=0x1234 -> lsu_ready=1; next cycle reg_write=0.
- Scoreboard RAW: issue_valid with issue_rd=9, then chk_rs1=9.
  - hazard=1 until the LSU grant for rd 9.
  - Cycle after the grant: hazard stays 1 (output stage holds write to 9).
  - One cycle later: hazard=0.
  - chk_rs1=0 -> hazard=0 throughout.
- Same-edge set/clear: ALU grant rd=4 while issue_valid with issue_rd=4 -> busy[4] remains 1; chk_rd=4 gives hazard=1 after the edge.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback, issue, hazard-check and register-file write bundle; master drives requests, slave is the scheduler
interface regfile_wb_scheduler_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic [AW-1:0]   chk_rd;
  logic            hazard;
  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    input  alu_ready, lsu_ready, hazard, reg_write, write_reg, write_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
    output alu_ready, lsu_ready, hazard, reg_write, write_reg, write_data
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin ALU/LSU writeback arbiter with busy scoreboard; ports clk, reset, bus (slave: handshakes, issue, hazard check, regfile write)
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_scheduler_if.slave bus
);
  localparam int N = 2 ** AW;
  logic            rr_ptr;
  logic [N-1:0]    busy;
  logic            grant_lsu;
  logic            grant_any;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic [N-1:0]    set_mask;
  logic [N-1:0]    clr_mask;
  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;
  function automatic logic hit(input logic [AW-1:0] r, input logic [N-1:0] b, input logic we, input logic [AW-1:0] wr);
    return r != '0 && (b[r] || (we && wr == r));
  endfunction
  always_comb begin
    grant_lsu = bus.lsu_valid && (!bus.alu_valid || rr_ptr);
    grant_any = bus.alu_valid || bus.lsu_valid;
    g_rd      = grant_lsu ? bus.lsu_rd : bus.alu_rd;
    g_data    = grant_lsu ? bus.lsu_data : bus.alu_data;
    set_mask  = (bus.issue_valid && bus.issue_rd != '0) ? {{(N-1){1'b0}}, 1'b1} << bus.issue_rd : '0;
    clr_mask  = (grant_any && g_rd != '0) ? {{(N-1){1'b0}}, 1'b1} << g_rd : '0;
  end
  assign bus.alu_ready  = bus.alu_valid && !grant_lsu;
  assign bus.lsu_ready  = grant_lsu;
  assign bus.reg_write  = reg_write;
  assign bus.write_reg  = write_reg;
  assign bus.write_data = write_data;
  assign bus.hazard     = hit(bus.chk_rs1, busy, reg_write, write_reg) ||
                          hit(bus.chk_rs2, busy, reg_write, write_reg) ||
                          hit(bus.chk_rd,  busy, reg_write, write_reg);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      rr_ptr     <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      busy      <= (busy & ~clr_mask) | set_mask;
      reg_write <= grant_any && g_rd != '0;
      if (bus.alu_valid && bus.lsu_valid) rr_ptr <= !grant_lsu;
      if (grant_any) begin
        write_reg  <= g_rd;
        write_data <= g_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  logic [4:0]  last_rd;
  logic [31:0] last_data;
  regfile_wb_scheduler_if #(.XLEN(32), .AW(5)) bus ();
  regfile_wb_scheduler #(.XLEN(32), .AW(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic g, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    if (g) begin
      last_rd   = rd;
      last_data = d;
    end
    e.we   = g && rd != 5'd0;
    e.rd   = last_rd;
    e.data = last_data;
    q.push_back(e);
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(e.we));
      chk({tag, ".write_reg"}, 32'(bus.write_reg), 32'(e.rd));
      chk({tag, ".write_data"}, bus.write_data, e.data);
    end
  endtask
  task automatic rdy(input string tag, input logic a, input logic l);
    chk({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(a));
    chk({tag, ".lsu_ready"}, 32'(bus.lsu_ready), 32'(l));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;
    last_rd = 5'd0; last_data = 32'h0;
    for (int i = 0; i < 2; i++) begin
      q.push_back('{we: 1'b0, rd: 5'd0, data: 32'h0});
      tick("reset");
    end
    reset = 1'b0;
    bus.issue_valid = 1'b0;
    bus.chk_rs1 = 5'd6; bus.chk_rs2 = 5'd5;
    #1 chk("reset.no_busy", 32'(bus.hazard), 32'd0);
    rdy("post_reset", 1'b1, 1'b0);
    push(1'b1, 5'd5, 32'h55);
    tick("post_reset");
    bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd5;
    #1 chk("out_stage_hazard", 32'(bus.hazard), 32'd1);
    bus.chk_rd = 5'd0;
    bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
    #1 rdy("alu_alone", 1'b1, 1'b0);
    push(1'b1, 5'd3, 32'hDEADBEEF);
    tick("alu_alone");
    bus.alu_valid = 1'b0;
    #1 rdy("idle", 1'b0, 1'b0);
    push(1'b0, 5'd0, 32'h0);
    tick("idle");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hB7;
    #1 rdy("rr0", 1'b1, 1'b0);
    push(1'b1, 5'd1, 32'hA1);
    tick("rr0");
    bus.alu_rd = 5'd2; bus.alu_data = 32'hA2;
    #1 rdy("rr1", 1'b0, 1'b1);
    push(1'b1, 5'd7, 32'hB7);
    tick("rr1");
    bus.lsu_data = 32'hB8;
    #1 rdy("rr2", 1'b1, 1'b0);
    push(1'b1, 5'd2, 32'hA2);
    tick("rr2");
    bus.alu_rd = 5'd1; bus.alu_data = 32'hA3;
    #1 rdy("rr3", 1'b0, 1'b1);
    push(1'b1, 5'd7, 32'hB8);
    tick("rr3");
    bus.alu_valid = 1'b0;
    bus.lsu_rd = 5'd0; bus.lsu_data = 32'h1234;
    #1 rdy("lsu_x0", 1'b0, 1'b1);
    push(1'b1, 5'd0, 32'h1234);
    tick("lsu_x0");
    bus.lsu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    push(1'b0, 5'd0, 32'h0);
    tick("issue9");
    bus.issue_valid = 1'b0;
    bus.chk_rs1 = 5'd0;
    #1 chk("raw.rs1_x0", 32'(bus.hazard), 32'd0);
    bus.chk_rs1 = 5'd9;
    #1 chk("raw.busy", 32'(bus.hazard), 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick("raw.wait");
    chk("raw.still_busy", 32'(bus.hazard), 32'd1);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    #1 rdy("raw.grant", 1'b0, 1'b1);
    chk("raw.grant_cycle", 32'(bus.hazard), 32'd1);
    push(1'b1, 5'd9, 32'h99);
    tick("raw.grant");
    bus.lsu_valid = 1'b0;
    #1 chk("raw.out_stage", 32'(bus.hazard), 32'd1);
    push(1'b0, 5'd0, 32'h0);
    tick("raw.drain");
    chk("raw.cleared", 32'(bus.hazard), 32'd0);
    bus.chk_rs1 = 5'd0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    push(1'b0, 5'd0, 32'h0);
    tick("issue4");
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    #1 rdy("same_edge", 1'b1, 1'b0);
    push(1'b1, 5'd4, 32'h44);
    tick("same_edge");
    bus.alu_valid = 1'b0; bus.issue_valid = 1'b0;
    push(1'b0, 5'd0, 32'h0);
    tick("same_edge.drain");
    bus.chk_rd = 5'd4;
    #1 chk("waw.rd4", 32'(bus.hazard), 32'd1);
    bus.chk_rd = 5'd0; bus.chk_rs2 = 5'd4;
    #1 chk("raw.rs2_4", 32'(bus.hazard), 32'd1);
    bus.chk_rs2 = 5'd7;
    #1 chk("no_hazard.rs2_7", 32'(bus.hazard), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
